// File: rtl/mp_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_table_pkg
// Description : Shared types and helpers for the multi-port register table.
//               - clr_state_e : clear-engine states
//               - idx_width   : index width for a given table size
//               - slice_lo/hi : bit bounds of port p inside a packed port bus
// Revision    : 1.0 - initial release
// ============================================================================
package mp_table_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Index width; sizes that are not a power of two round up.
  function automatic int idx_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

  // Lowest bit of port p in a bus made of w-bit fields.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction

  // Highest bit of port p in a bus made of w-bit fields.
  function automatic int slice_hi(input int p, input int w);
    return (p * w) + w - 1;
  endfunction

endpackage : mp_table_pkg
`default_nettype wire

// File: rtl/mp_table_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mp_table_wr_arb
// Description : Per-entry write resolver. For every table entry it produces a
//               write strobe and write data from all write ports plus the
//               clear engine. Among ports hitting the same entry the highest-
//               numbered port wins; the clear engine overrides all ports.
// Ports       : wr_en/index_wr/data_wr - packed write ports
//               wr_rdy                 - port writes allowed this cycle
//               clr_active/clr_ptr     - clear engine erasing entry clr_ptr
//               ent_we/ent_wd          - resolved per-entry strobe and data
// Revision    : 1.0 - initial release
// ============================================================================
module mp_table_wr_arb
  import mp_table_pkg::*;
#(
  parameter int                    TABLE_SIZE = 32,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WR_PORTS   = 2,
  parameter int                    IDX_W      = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]      index_wr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] data_wr,
  input  logic                           wr_rdy,
  input  logic                           clr_active,
  input  logic [IDX_W-1:0]               clr_ptr,
  output logic                           ent_we [TABLE_SIZE],
  output logic [DATA_WIDTH-1:0]          ent_wd [TABLE_SIZE]
);

  always_comb begin
    for (int e = 0; e < TABLE_SIZE; e++) begin
      ent_we[e] = 1'b0;
      ent_wd[e] = '0;
      // Ascending scan: a later (higher) port overwrites an earlier hit.
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && wr_rdy &&
            (index_wr[slice_lo(p, IDX_W) +: IDX_W] == IDX_W'(e))) begin
          ent_we[e] = 1'b1;
          ent_wd[e] = data_wr[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
      // Port writes are blocked while clearing, but the walk wins regardless.
      if (clr_active && (clr_ptr == IDX_W'(e))) begin
        ent_we[e] = 1'b1;
        ent_wd[e] = INIT_VALUE;
      end
    end
  end

endmodule : mp_table_wr_arb
`default_nettype wire

// File: rtl/mp_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mp_table_ctrl
// Description : Parametrised multi-port register table with registered reads,
//               highest-port write priority, optional write-to-read bypass,
//               sticky out-of-range flag and a sequential clear engine.
// Ports       : clk, rst (sync, active-low)
//               wr_en/index_wr/data_wr - WR_PORTS packed write ports
//               wr_rdy                 - writes accepted when high
//               rd_en/index_rd         - RD_PORTS packed read ports
//               data_rd/rd_valid       - registered read data and valid
//               clr_req                - start a clear walk
//               clr_busy/clr_done      - walk in progress / completion pulse
//               oob_err                - sticky out-of-range access flag
// Revision    : 1.0 - initial release
// ============================================================================
module mp_table_ctrl
  import mp_table_pkg::*;
#(
  parameter int                    TABLE_SIZE = 32,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WR_PORTS   = 2,
  parameter int                    RD_PORTS   = 2,
  parameter bit                    RD_BYPASS  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   IDX_W      = idx_width(TABLE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]      index_wr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] data_wr,
  output logic                           wr_rdy,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*IDX_W-1:0]      index_rd,
  output logic [RD_PORTS*DATA_WIDTH-1:0] data_rd,
  output logic [RD_PORTS-1:0]            rd_valid,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic                           clr_done,
  output logic                           oob_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);
  localparam logic [IDX_W:0]   SIZE_EXT = (IDX_W + 1)'(TABLE_SIZE);

  logic [DATA_WIDTH-1:0] mem      [TABLE_SIZE];
  logic                  ent_we   [TABLE_SIZE];
  logic [DATA_WIDTH-1:0] ent_wd   [TABLE_SIZE];
  logic [DATA_WIDTH-1:0] rd_next  [RD_PORTS];
  logic [DATA_WIDTH-1:0] rd_q     [RD_PORTS];
  logic [IDX_W-1:0]      clr_ptr;
  logic                  clr_active;
  logic                  oob_hit;
  clr_state_e            state;

  // Extra leading zero keeps the compare meaningful for power-of-two sizes.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < SIZE_EXT);
  endfunction

  assign wr_rdy     = !clr_busy;
  assign clr_active = (state == CLEAR);

  mp_table_wr_arb #(
    .TABLE_SIZE (TABLE_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .WR_PORTS   (WR_PORTS),
    .IDX_W      (IDX_W),
    .INIT_VALUE (INIT_VALUE)
  ) u_wr_arb (
    .wr_en      (wr_en),
    .index_wr   (index_wr),
    .data_wr    (data_wr),
    .wr_rdy     (wr_rdy),
    .clr_active (clr_active),
    .clr_ptr    (clr_ptr),
    .ent_we     (ent_we),
    .ent_wd     (ent_wd)
  );

  // Table storage.
  always_ff @(posedge clk) begin
    for (int e = 0; e < TABLE_SIZE; e++) begin
      if (!rst) begin
        mem[e] <= INIT_VALUE;
      end else if (ent_we[e]) begin
        mem[e] <= ent_wd[e];
      end
    end
  end

  // Read data selection. With bypass the resolved write of this cycle
  // (port data or the clear walk) is returned instead of the stored value.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_next[p] = '0;
      if (in_range(index_rd[slice_lo(p, IDX_W) +: IDX_W])) begin
        if (RD_BYPASS && ent_we[index_rd[slice_lo(p, IDX_W) +: IDX_W]]) begin
          rd_next[p] = ent_wd[index_rd[slice_lo(p, IDX_W) +: IDX_W]];
        end else begin
          rd_next[p] = mem[index_rd[slice_lo(p, IDX_W) +: IDX_W]];
        end
      end
    end
  end

  // Any enabled access with an out-of-range index.
  always_comb begin
    oob_hit = 1'b0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p] && !in_range(index_wr[slice_lo(p, IDX_W) +: IDX_W])) begin
        oob_hit = 1'b1;
      end
    end
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_en[p] && !in_range(index_rd[slice_lo(p, IDX_W) +: IDX_W])) begin
        oob_hit = 1'b1;
      end
    end
  end

  // Registered read ports; data holds when the port is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= '0;
      oob_err  <= 1'b0;
      for (int p = 0; p < RD_PORTS; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      rd_valid <= rd_en;
      if (oob_hit) begin
        oob_err <= 1'b1;
      end
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p]) begin
          rd_q[p] <= rd_next[p];
        end
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    assign data_rd[slice_hi(p, DATA_WIDTH):slice_lo(p, DATA_WIDTH)] = rd_q[p];
  end

  // Clear engine. clr_busy mirrors CLEAR so the walk lasts TABLE_SIZE
  // busy cycles, one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      clr_ptr  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST_IDX) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule : mp_table_ctrl
`default_nettype wire

// File: tb/tb_mp_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_table_ctrl
// Description : Self-checking bench for mp_table_ctrl. Three instances share
//               one stimulus: 32 entries with bypass, 32 entries without
//               bypass, 20 entries with bypass. A behavioural table model
//               predicts every output of every instance each cycle; directed
//               vectors and sequences add explicit expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_table_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  index_wr;
  logic [15:0] data_wr;
  logic [1:0]  rd_en;
  logic [9:0]  index_rd;
  logic        clr_req;

  logic [15:0] data_rd_o  [NI];
  logic [1:0]  rd_valid_o [NI];
  logic        wr_rdy_o   [NI];
  logic        clr_busy_o [NI];
  logic        clr_done_o [NI];
  logic        oob_o      [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    mp_table_ctrl #(
      .TABLE_SIZE ((i == 2) ? 20 : 32),
      .DATA_WIDTH (8),
      .WR_PORTS   (2),
      .RD_PORTS   (2),
      .RD_BYPASS  ((i == 1) ? 1'b0 : 1'b1),
      .INIT_VALUE (8'h00)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .index_wr (index_wr),
      .data_wr  (data_wr),
      .wr_rdy   (wr_rdy_o[i]),
      .rd_en    (rd_en),
      .index_rd (index_rd),
      .data_rd  (data_rd_o[i]),
      .rd_valid (rd_valid_o[i]),
      .clr_req  (clr_req),
      .clr_busy (clr_busy_o[i]),
      .clr_done (clr_done_o[i]),
      .oob_err  (oob_o[i])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain arrays, a countdown for the clear walk.
  // --------------------------------------------------------------------------
  int         sz  [NI] = '{32, 32, 20};
  bit         byp [NI] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] mm  [NI][32];
  logic [7:0] nm  [32];
  int         left  [NI];
  bit         mdone [NI];
  bit         moob  [NI];
  logic [7:0] ed    [NI][2];
  logic [1:0] ev    [NI];

  task automatic model_step();
    int idx;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        for (int e = 0; e < 32; e++) mm[i][e] = 8'h00;
        left[i] = 0; mdone[i] = 1'b0; moob[i] = 1'b0;
        ed[i][0] = 8'h00; ed[i][1] = 8'h00; ev[i] = 2'b00;
      end else begin
        for (int e = 0; e < 32; e++) nm[e] = mm[i][e];
        for (int p = 0; p < 2; p++) begin
          idx = int'(index_wr[p*5 +: 5]);
          if (wr_en[p]) begin
            if (idx >= sz[i]) moob[i] = 1'b1;
            else if (left[i] == 0) nm[idx] = data_wr[p*8 +: 8];
          end
        end
        if (left[i] > 0) nm[sz[i] - left[i]] = 8'h00;
        for (int p = 0; p < 2; p++) begin
          idx = int'(index_rd[p*5 +: 5]);
          ev[i][p] = rd_en[p];
          if (rd_en[p]) begin
            if (idx >= sz[i]) begin
              ed[i][p] = 8'h00;
              moob[i]  = 1'b1;
            end else begin
              ed[i][p] = byp[i] ? nm[idx] : mm[i][idx];
            end
          end
        end
        for (int e = 0; e < 32; e++) mm[i][e] = nm[e];
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) mdone[i] = 1'b1;
        end else if (mdone[i]) begin
          mdone[i] = 1'b0;
        end else if (clr_req) begin
          left[i] = sz[i];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("m%0d.wr_rdy", i),   32'(wr_rdy_o[i]),   32'(left[i] == 0));
      check($sformatf("m%0d.clr_busy", i), 32'(clr_busy_o[i]), 32'(left[i] != 0));
      check($sformatf("m%0d.clr_done", i), 32'(clr_done_o[i]), 32'(mdone[i]));
      check($sformatf("m%0d.oob_err", i),  32'(oob_o[i]),      32'(moob[i]));
      check($sformatf("m%0d.rd_valid", i), 32'(rd_valid_o[i]), 32'(ev[i]));
      check($sformatf("m%0d.data_rd", i),  32'(data_rd_o[i]),  32'({ed[i][1], ed[i][0]}));
    end
  end

  // --------------------------------------------------------------------------
  // Directed vectors: expected read data for the bypass (b) and non-bypass
  // (n) 32-entry instances, one cycle after the inputs are applied.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  wen;
    logic [9:0]  widx;
    logic [15:0] wdat;
    logic [1:0]  ren;
    logic [9:0]  ridx;
    logic [7:0]  eb0, eb1, en0, en1;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] wen, input int wi0, input int wi1,
                              input int wd0, input int wd1, input logic [1:0] ren,
                              input int ri0, input int ri1, input int eb0, input int eb1,
                              input int en0, input int en1);
    vec_t v;
    v.wen  = wen;
    v.widx = {5'(wi1), 5'(wi0)};
    v.wdat = {8'(wd1), 8'(wd0)};
    v.ren  = ren;
    v.ridx = {5'(ri1), 5'(ri0)};
    v.eb0 = 8'(eb0); v.eb1 = 8'(eb1); v.en0 = 8'(en0); v.en1 = 8'(en1);
    return v;
  endfunction

  vec_t vecs [8];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; index_wr = '0; data_wr = '0;
    rd_en = 2'b00; index_rd = '0; clr_req = 1'b0;
  endtask

  int busy_cnt, done_cnt, last_busy, done_at;

  initial begin
    rst = 1'b0;
    idle_inputs();

    vecs[0] = mk(2'b00, 0, 0, 0, 0,          2'b11, 0, 31, 0, 0, 0, 0);
    vecs[1] = mk(2'b11, 5, 5, 'h11, 'h22,    2'b00, 0, 0,  0, 0, 0, 0);
    vecs[2] = mk(2'b00, 0, 0, 0, 0,          2'b11, 5, 5,  'h22, 'h22, 'h22, 'h22);
    vecs[3] = mk(2'b01, 7, 0, 'hA5, 0,       2'b11, 7, 5,  'hA5, 'h22, 'h00, 'h22);
    vecs[4] = mk(2'b00, 0, 0, 0, 0,          2'b11, 7, 7,  'hA5, 'hA5, 'hA5, 'hA5);
    vecs[5] = mk(2'b11, 9, 9, 'h33, 'h44,    2'b11, 31, 9, 'h00, 'h44, 'h00, 'h00);
    vecs[6] = mk(2'b10, 31, 31, 'hEE, 'hFF,  2'b11, 31, 31, 'hFF, 'hFF, 'h00, 'h00);
    vecs[7] = mk(2'b00, 0, 0, 0, 0,          2'b11, 9, 31, 'h44, 'hFF, 'h44, 'hFF);

    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("rst.wr_rdy",   32'(wr_rdy_o[0]),   32'd1);
    check("rst.clr_busy", 32'(clr_busy_o[0]), 32'd0);
    check("rst.clr_done", 32'(clr_done_o[0]), 32'd0);
    check("rst.oob_err",  32'(oob_o[0]),      32'd0);
    check("rst.rd_valid", 32'(rd_valid_o[0]), 32'd0);
    check("rst.data_rd",  32'(data_rd_o[0]),  32'd0);

    for (int k = 0; k < 8; k++) begin
      wr_en = vecs[k].wen; index_wr = vecs[k].widx; data_wr = vecs[k].wdat;
      rd_en = vecs[k].ren; index_rd = vecs[k].ridx;
      cyc();
      check($sformatf("vec%0d.byp.data", k),   32'(data_rd_o[0]),  32'({vecs[k].eb1, vecs[k].eb0}));
      check($sformatf("vec%0d.nobyp.data", k), 32'(data_rd_o[1]),  32'({vecs[k].en1, vecs[k].en0}));
      check($sformatf("vec%0d.valid", k),      32'(rd_valid_o[0]), 32'(vecs[k].ren));
    end
    idle_inputs();

    // Fill with index+1, then run a full clear walk.
    for (int k = 0; k < 16; k++) begin
      wr_en    = 2'b11;
      index_wr = {5'(2*k + 1), 5'(2*k)};
      data_wr  = {8'(2*k + 2), 8'(2*k + 1)};
      cyc();
    end
    idle_inputs();
    rd_en = 2'b11; index_rd = {5'd31, 5'd3};
    cyc();
    check("fill.idx3_31", 32'(data_rd_o[0]), 32'h2004);
    idle_inputs();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; last_busy = -1; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (clr_busy_o[0]) begin busy_cnt++; last_busy = c; end
      if (clr_done_o[0]) begin done_cnt++; done_at = c; end
      if (c == 5) begin
        check("clr.wr_rdy_low", 32'(wr_rdy_o[0]), 32'd0);
        wr_en = 2'b01; index_wr = 10'd3; data_wr = 16'h0077;
      end else begin
        wr_en = 2'b00;
      end
      cyc();
    end
    check("clr.busy_cycles", busy_cnt, 32);
    check("clr.done_pulses", done_cnt, 1);
    check("clr.done_after_busy", done_at, last_busy + 1);
    for (int k = 0; k < 16; k++) begin
      rd_en = 2'b11; index_rd = {5'(2*k + 1), 5'(2*k)};
      cyc();
      check($sformatf("clr.read%0d", 2*k), 32'(data_rd_o[0]), 32'h0000);
    end
    idle_inputs();

    // Reset in the middle of a walk.
    wr_en = 2'b01; index_wr = 10'd20; data_wr = 16'h005A;
    cyc();
    idle_inputs();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (9) cyc();
    check("midrst.busy_before", 32'(clr_busy_o[0]), 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("midrst.busy", 32'(clr_busy_o[0]), 32'd0);
    check("midrst.done", 32'(clr_done_o[0]), 32'd0);
    check("midrst.wr_rdy", 32'(wr_rdy_o[0]), 32'd1);
    rd_en = 2'b01; index_rd = 10'd20;
    cyc();
    check("midrst.idx20", 32'(data_rd_o[0][7:0]), 32'h00);
    rd_en = 2'b00;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    check("midrst.restart", 32'(clr_busy_o[0]), 32'd1);
    repeat (40) cyc();

    // Out-of-range access on the 20-entry instance.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    wr_en = 2'b01; index_wr = 10'd25; data_wr = 16'h0099;
    cyc();
    idle_inputs();
    check("oob.set20", 32'(oob_o[2]), 32'd1);
    check("oob.clear32", 32'(oob_o[0]), 32'd0);
    rd_en = 2'b11; index_rd = {5'd5, 5'd25};
    cyc();
    check("oob.read_data", 32'(data_rd_o[2]), 32'h0000);
    check("oob.read_valid", 32'(rd_valid_o[2]), 32'd3);
    check("oob.inrange32", 32'(data_rd_o[0][7:0]), 32'h99);
    idle_inputs();
    repeat (5) cyc();
    check("oob.sticky", 32'(oob_o[2]), 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("oob.reset", 32'(oob_o[2]), 32'd0);

    // Random traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 199) != 0);
      wr_en    = 2'($urandom);
      index_wr = 10'($urandom);
      data_wr  = 16'($urandom);
      rd_en    = 2'($urandom);
      index_rd = 10'($urandom);
      clr_req  = ($urandom_range(0, 29) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mp_table_ctrl
`default_nettype wire
